// File: rtl/interrupt_ack_sequencer.sv
// PIC interrupt service sequencer: raises INT, tracks the two-pulse INTA handshake,
// owns the ISR and priority rotation, handles EOI. Optional automatic EOI: PIC_AUTO_EOI_EN.
module interrupt_ack_sequencer #(
  parameter logic [2:0] RESET_ROTATE = 3'd7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] interrupt,
  input  logic       interrupt_acknowledge_n,
  input  logic       end_of_interrupt,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       rotate_on_eoi,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] in_service_register,
  output logic [2:0] priority_rotate,
  output logic [7:0] vector_out,
  output logic       vector_valid
);

  typedef enum logic [1:0] {IDLE, PENDING, ACK1, ACK2} state_e;

  state_e     state_q, state_d;
  logic       int_q, int_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] rot_q, rot_d;
  logic [7:0] vec_q, vec_d;
  logic       vvalid_q, vvalid_d;
  logic [2:0] ack_q, ack_d;
  logic       spur_q, spur_d;
  logic       inta_prev_q;

  logic       fall, rise;
  logic [2:0] req_level;
  logic       eoi_found;
  logic [2:0] eoi_hi_level;
  logic [2:0] cand;
  logic [7:0] set_mask, clr_mask;

  assign fall = inta_prev_q & ~interrupt_acknowledge_n;
  assign rise = ~inta_prev_q & interrupt_acknowledge_n;

  always_comb begin
    req_level = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (interrupt[i]) req_level = 3'(i);
    end
  end

  // Highest-priority in-service level, evaluated on the pre-update ISR.
  always_comb begin
    eoi_found    = 1'b0;
    eoi_hi_level = 3'd0;
    cand         = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = rot_q + 3'(k);
      if (!eoi_found && isr_q[cand]) begin
        eoi_found    = 1'b1;
        eoi_hi_level = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    int_d    = int_q;
    rot_d    = rot_q;
    vec_d    = vec_q;
    vvalid_d = vvalid_q;
    ack_d    = ack_q;
    spur_d   = spur_q;
    set_mask = 8'h00;
    clr_mask = 8'h00;

    case (state_q)
      IDLE: begin
        if (|interrupt) begin
          int_d   = 1'b1;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (fall) begin
          int_d = 1'b0;
          if (|interrupt) begin
            ack_d               = req_level;
            set_mask[req_level] = 1'b1;
            spur_d              = 1'b0;
          end else begin
            ack_d  = 3'd7;
            spur_d = 1'b1;
          end
          state_d = ACK1;
        end
      end
      ACK1: begin
        if (fall) begin
          vec_d    = {vector_base, ack_q};
          vvalid_d = 1'b1;
          state_d  = ACK2;
        end
      end
      ACK2: begin
        if (rise) begin
          vvalid_d = 1'b0;
          state_d  = IDLE;
`ifdef PIC_AUTO_EOI_EN
          if (!spur_q) begin
            clr_mask[ack_q] = 1'b1;
            if (rotate_on_eoi) rot_d = ack_q;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // An explicit EOI takes precedence over the automatic one for rotation.
    if (end_of_interrupt) begin
      if (eoi_specific) begin
        clr_mask[eoi_level] = 1'b1;
        if (rotate_on_eoi) rot_d = eoi_level;
      end else if (eoi_found) begin
        clr_mask[eoi_hi_level] = 1'b1;
        if (rotate_on_eoi) rot_d = eoi_hi_level;
      end
    end

    isr_d = (isr_q & ~clr_mask) | set_mask;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      int_q       <= 1'b0;
      isr_q       <= 8'h00;
      rot_q       <= RESET_ROTATE;
      vec_q       <= 8'h00;
      vvalid_q    <= 1'b0;
      ack_q       <= 3'd0;
      spur_q      <= 1'b0;
      inta_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      int_q       <= int_d;
      isr_q       <= isr_d;
      rot_q       <= rot_d;
      vec_q       <= vec_d;
      vvalid_q    <= vvalid_d;
      ack_q       <= ack_d;
      spur_q      <= spur_d;
      inta_prev_q <= interrupt_acknowledge_n;
    end
  end

  assign int_out             = int_q;
  assign in_service_register = isr_q;
  assign priority_rotate     = rot_q;
  assign vector_out          = vec_q;
  assign vector_valid        = vvalid_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench for interrupt_ack_sequencer: directed scenarios plus randomized
// cycles/EOIs against a behavioural ISR/rotation model.
module tb_interrupt_ack_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] interrupt;
  logic       interrupt_acknowledge_n;
  logic       end_of_interrupt;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       rotate_on_eoi;
  logic [4:0] vector_base;
  logic       int_out;
  logic [7:0] in_service_register;
  logic [2:0] priority_rotate;
  logic [7:0] vector_out;
  logic       vector_valid;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] m_isr;
  int         m_rot;

  interrupt_ack_sequencer dut (
    .clock                   (clock),
    .reset                   (reset),
    .interrupt               (interrupt),
    .interrupt_acknowledge_n (interrupt_acknowledge_n),
    .end_of_interrupt        (end_of_interrupt),
    .eoi_specific            (eoi_specific),
    .eoi_level               (eoi_level),
    .rotate_on_eoi           (rotate_on_eoi),
    .vector_base             (vector_base),
    .int_out                 (int_out),
    .in_service_register     (in_service_register),
    .priority_rotate         (priority_rotate),
    .vector_out              (vector_out),
    .vector_valid            (vector_valid)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    m_isr = 8'h00;
    m_rot = 7;
    step();
  endtask

  task automatic test_reset();
    interrupt = 8'h00; interrupt_acknowledge_n = 1'b1; end_of_interrupt = 1'b0;
    eoi_specific = 1'b0; eoi_level = 3'd0; rotate_on_eoi = 1'b0; vector_base = 5'h10;
    reset = 1'b1;
    #2;
    n_total++;
    if ({int_out, in_service_register, priority_rotate, vector_out, vector_valid} !==
        {1'b0, 8'h00, 3'd7, 8'h00, 1'b0})
      $display("FAIL reset_values: got int=%b isr=%h rot=%0d vec=%h vv=%b, want 0 00 7 00 0",
               int_out, in_service_register, priority_rotate, vector_out, vector_valid);
    else n_pass++;
    reset = 1'b0;
    m_isr = 8'h00;
    m_rot = 7;
    step();
  endtask

  // Full INTA handshake; withdraw drops the request before the first INTA (spurious).
  task automatic run_cycle(input logic [7:0] req, input logic [4:0] base,
                           input bit withdraw, input bit rot_eoi);
    int lvl;
    bit spur;
    vector_base = base;
    interrupt   = req;
    step();
    n_total++;
    if (int_out !== 1'b1) $display("FAIL int_raise: got %b want 1", int_out);
    else n_pass++;
    if (withdraw) begin
      interrupt = 8'h00;
      step();
      n_total++;
      if (int_out !== 1'b1) $display("FAIL int_hold_withdrawn: got %b want 1", int_out);
      else n_pass++;
    end
    spur = withdraw;
    lvl  = spur ? 7 : $clog2(req);
    interrupt_acknowledge_n = 1'b0;
    step();
    if (!spur) m_isr[lvl] = 1'b1;
    n_total++;
    if (in_service_register !== m_isr || int_out !== 1'b0)
      $display("FAIL first_inta: got isr=%h int=%b want isr=%h int=0",
               in_service_register, int_out, m_isr);
    else n_pass++;
    interrupt = 8'($urandom);
    interrupt_acknowledge_n = 1'b1;
    step();
    n_total++;
    if (vector_valid !== 1'b0) $display("FAIL ack1_rise_ignored: got vv=%b want 0", vector_valid);
    else n_pass++;
    interrupt = 8'h00;
    interrupt_acknowledge_n = 1'b0;
    step();
    n_total++;
    if (vector_valid !== 1'b1 || vector_out !== {base, 3'(lvl)})
      $display("FAIL vector: got vv=%b vec=%h want vv=1 vec=%h", vector_valid, vector_out,
               {base, 3'(lvl)});
    else n_pass++;
    interrupt_acknowledge_n = 1'b1;
    rotate_on_eoi = rot_eoi;
    step();
    rotate_on_eoi = 1'b0;
`ifdef PIC_AUTO_EOI_EN
    if (!spur) begin
      m_isr[lvl] = 1'b0;
      if (rot_eoi) m_rot = lvl;
    end
`endif
    n_total++;
    if (vector_valid !== 1'b0 || vector_out !== {base, 3'(lvl)} ||
        in_service_register !== m_isr || priority_rotate !== 3'(m_rot))
      $display("FAIL ack2_rise: got vv=%b vec=%h isr=%h rot=%0d want vv=0 vec=%h isr=%h rot=%0d",
               vector_valid, vector_out, in_service_register, priority_rotate,
               {base, 3'(lvl)}, m_isr, m_rot);
    else n_pass++;
  endtask

  task automatic do_eoi(input bit spec, input int lvl, input bit rot);
    end_of_interrupt = 1'b1;
    eoi_specific     = spec;
    eoi_level        = 3'(lvl);
    rotate_on_eoi    = rot;
    step();
    end_of_interrupt = 1'b0;
    rotate_on_eoi    = 1'b0;
    if (spec) begin
      m_isr[lvl] = 1'b0;
      if (rot) m_rot = lvl;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        if (m_isr[(m_rot + k) % 8]) begin
          m_isr[(m_rot + k) % 8] = 1'b0;
          if (rot) m_rot = (m_rot + k) % 8;
          break;
        end
      end
    end
    n_total++;
    if (in_service_register !== m_isr || priority_rotate !== 3'(m_rot))
      $display("FAIL eoi(spec=%0d lvl=%0d rot=%0d): got isr=%h rot=%0d want isr=%h rot=%0d",
               spec, lvl, rot, in_service_register, priority_rotate, m_isr, m_rot);
    else n_pass++;
  endtask

  task automatic test_basic_cycle();
    apply_reset();
    run_cycle(8'h04, 5'h10, 0, 0);
    n_total++;
    if (vector_out !== 8'h82) $display("FAIL basic_vector: got %h want 82", vector_out);
    else n_pass++;
  endtask

  task automatic test_eoi_nonspecific();
    for (int r = 0; r < 2; r++) begin
      apply_reset();
      run_cycle(8'h01, 5'h10, 0, 0);
      run_cycle(8'h04, 5'h10, 0, 0);
      do_eoi(0, 0, r[0]);
      n_total++;
      if (in_service_register !== 8'h04 || priority_rotate !== (r[0] ? 3'd0 : 3'd7))
        $display("FAIL eoi_nonspecific(rot=%0d): got isr=%h rot=%0d want isr=04 rot=%0d",
                 r, in_service_register, priority_rotate, r[0] ? 0 : 7);
      else n_pass++;
    end
  endtask

  task automatic test_eoi_specific();
    apply_reset();
    run_cycle(8'h10, 5'h10, 0, 0);
    do_eoi(1, 2, 0);
    n_total++;
    if (in_service_register !== 8'h10) $display("FAIL eoi_specific_noop: got %h want 10",
                                                in_service_register);
    else n_pass++;
    do_eoi(1, 4, 1);
    n_total++;
    if (in_service_register !== 8'h00 || priority_rotate !== 3'd4)
      $display("FAIL eoi_specific_rot: got isr=%h rot=%0d want 00 4",
               in_service_register, priority_rotate);
    else n_pass++;
  endtask

  task automatic test_spurious();
    apply_reset();
    run_cycle(8'h08, 5'h10, 1, 0);
    n_total++;
    if (vector_out !== 8'h87 || in_service_register !== 8'h00)
      $display("FAIL spurious: got vec=%h isr=%h want 87 00", vector_out, in_service_register);
    else n_pass++;
  endtask

  task automatic test_reset_mid_cycle();
    apply_reset();
    interrupt = 8'h08;
    step();
    interrupt_acknowledge_n = 1'b0;
    step();
    interrupt = 8'h00;
    interrupt_acknowledge_n = 1'b1;
    step();
    n_total++;
    if (in_service_register !== 8'h08) $display("FAIL pre_reset_isr: got %h want 08",
                                                in_service_register);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if ({int_out, in_service_register, priority_rotate, vector_out, vector_valid} !==
        {1'b0, 8'h00, 3'd7, 8'h00, 1'b0})
      $display("FAIL reset_mid_ack1: got int=%b isr=%h rot=%0d vec=%h vv=%b",
               int_out, in_service_register, priority_rotate, vector_out, vector_valid);
    else n_pass++;
    reset = 1'b0;
    m_isr = 8'h00;
    m_rot = 7;
    for (int p = 0; p < 4; p++) begin
      interrupt_acknowledge_n = p[0];
      step();
      n_total++;
      if (vector_valid !== 1'b0 || int_out !== 1'b0)
        $display("FAIL post_reset_inta%0d: got vv=%b int=%b want 0 0", p, vector_valid, int_out);
      else n_pass++;
    end
  endtask

  // Set+EOI on one bit (set wins), then a non-specific EOI seen against the old ISR.
  task automatic test_set_eoi_collision();
    apply_reset();
    interrupt = 8'h08;
    step();
    interrupt_acknowledge_n = 1'b0;
    end_of_interrupt = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3;
    step();
    end_of_interrupt = 1'b0;
    interrupt = 8'h00;
    n_total++;
    if (in_service_register !== 8'h08) $display("FAIL set_wins: got %h want 08",
                                                in_service_register);
    else n_pass++;
    for (int p = 0; p < 3; p++) begin
      interrupt_acknowledge_n = ~p[0];
      step();
    end
    interrupt = 8'h02;
    step();
    interrupt_acknowledge_n = 1'b0;
    end_of_interrupt = 1'b1; eoi_specific = 1'b0;
    step();
    end_of_interrupt = 1'b0;
    interrupt = 8'h00;
    n_total++;
    if (in_service_register !== 8'h02) $display("FAIL eoi_pre_update: got %h want 02",
                                                in_service_register);
    else n_pass++;
    for (int p = 0; p < 3; p++) begin
      interrupt_acknowledge_n = ~p[0];
      step();
    end
  endtask

`ifdef PIC_AUTO_EOI_EN
  task automatic test_auto_eoi();
    apply_reset();
    interrupt = 8'h02;
    step();
    interrupt_acknowledge_n = 1'b0;
    step();
    interrupt = 8'h00;
    n_total++;
    if (in_service_register !== 8'h02) $display("FAIL auto_eoi_between: got %h want 02",
                                                in_service_register);
    else n_pass++;
    for (int p = 0; p < 3; p++) begin
      interrupt_acknowledge_n = ~p[0];
      step();
    end
    n_total++;
    if (in_service_register !== 8'h00) $display("FAIL auto_eoi_after: got %h want 00",
                                                in_service_register);
    else n_pass++;
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0, 1: run_cycle(8'(1 << $urandom_range(0, 7)), 5'($urandom), 0, 1'($urandom));
        2:    run_cycle(8'(1 << $urandom_range(0, 7)), 5'($urandom), 1, 1'($urandom));
        default: do_eoi(1'($urandom), $urandom_range(0, 7), 1'($urandom));
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_basic_cycle();
`ifndef PIC_AUTO_EOI_EN
    test_eoi_nonspecific();
    test_eoi_specific();
    test_set_eoi_collision();
`else
    test_auto_eoi();
`endif
    test_spurious();
    test_reset_mid_cycle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
